// File: rtl/seven_seg_scanner_if.sv
// Datapath-side bundle for the seven-segment scanner:
// load strobe and digit data in, display pins out.
interface seven_seg_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     blank;
  logic                  lzs;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [DIGITS-1:0]     an;
  logic                  frame;

  modport master (
    output load, value, dp, blank, lzs,
    input  seg, dp_n, an, frame
  );

  modport slave (
    input  load, value, dp, blank, lzs,
    output seg, dp_n, an, frame
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with
// double-buffered digit data, blanking and zero suppression.
module seven_seg_scanner #(
  parameter int DIGITS      = 4,
  parameter int TICK_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  seven_seg_scanner_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYCLES - 1);
  localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

  logic [PW-1:0]     pcnt;
  logic [IW-1:0]     idx;
  logic              tick;
  logic              bnd;

  logic [VW-1:0]     p_value;
  logic [DIGITS-1:0] p_dp;
  logic [DIGITS-1:0] p_blank;
  logic              p_lzs;
  logic              pv;

  logic [VW-1:0]     a_value;
  logic [DIGITS-1:0] a_dp;
  logic [DIGITS-1:0] a_blank;
  logic              a_lzs;

  logic [DIGITS-1:0] zhi;
  logic [DIGITS-1:0] oh;
  logic [3:0]        nib;
  logic              cdp;
  logic              cblk;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign tick = (pcnt == PMAX);
  assign bnd  = tick && (idx == IMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (tick) begin
      pcnt <= '0;
      idx  <= (idx == IMAX) ? '0 : idx + 1'b1;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // A load on the boundary cycle bypasses P straight into A.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_value   <= '0;
      p_dp      <= '0;
      p_blank   <= '1;
      p_lzs     <= 1'b0;
      pv        <= 1'b0;
      a_value   <= '0;
      a_dp      <= '0;
      a_blank   <= '1;
      a_lzs     <= 1'b0;
      bus.frame <= 1'b0;
    end else begin
      bus.frame <= bnd;
      if (bus.load) begin
        p_value <= bus.value;
        p_dp    <= bus.dp;
        p_blank <= bus.blank;
        p_lzs   <= bus.lzs;
        pv      <= 1'b1;
      end
      if (bnd) begin
        if (bus.load) begin
          a_value <= bus.value;
          a_dp    <= bus.dp;
          a_blank <= bus.blank;
          a_lzs   <= bus.lzs;
        end else if (pv) begin
          a_value <= p_value;
          a_dp    <= p_dp;
          a_blank <= p_blank;
          a_lzs   <= p_lzs;
        end
        pv <= 1'b0;
      end
    end
  end

  // zhi[i]: nibbles i..DIGITS-1 of the active value are all zero
  always_comb begin
    zhi = '0;
    zhi[DIGITS-1] = (a_value[VW-1 -: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zhi[i] = zhi[i+1] && (a_value[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib  = '0;
    cdp  = 1'b0;
    cblk = 1'b1;
    oh   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib   = a_value[4*i +: 4];
        cdp   = a_dp[i];
        cblk  = a_blank[i] || (a_lzs && (i != 0) && zhi[i]);
        oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an   <= '1;
      bus.seg  <= 7'h7F;
      bus.dp_n <= 1'b1;
    end else if (cblk) begin
      bus.an   <= '1;
      bus.seg  <= 7'h7F;
      bus.dp_n <= 1'b1;
    end else begin
      bus.an   <= ~oh;
      bus.seg  <= hex7(nib);
      bus.dp_n <= ~cdp;
    end
  end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for a DIGITS-wide common-anode seven-segment display. It decodes one 4-bit hex nibble per digit and scans the anodes at a programmable rate. It adds per-digit decimal points, per-digit blanking and leading-zero suppression. Loaded values are double-buffered so the display changes only at a frame boundary, with no tearing. It sits between the datapath and the board display pins, replacing per-digit combinational decoders.

## Interface
- DIGITS, 4, number of digits scanned; legal range 1..8.
- TICK_CYCLES, 100000, clk cycles each digit stays lit; must be at least 2.
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, asynchronous and active-high.
- load  in  1  single-cycle strobe that captures value/dp/blank/lzs into the pending buffer.
- value  in  4*DIGITS  hex nibbles; digit i is value[4i+3:4i]; digit 0 is rightmost.
- dp  in  DIGITS  decimal-point enable per digit, 1 = lit.
- blank  in  DIGITS  per-digit blank, 1 = digit dark.
- lzs  in  1  leading-zero suppression enable.
- seg  out  7  cathodes, active-low, bit0 = a … bit6 = g.
- dp_n  out  1  decimal-point cathode, active-low.
- an  out  DIGITS  anodes, active-low, one-hot-low while a digit is lit.
- frame  out  1  one-cycle pulse marking a display-buffer update edge.

## Operation
- **Prescaler**
  - pcnt counts 0..TICK_CYCLES-1 and wraps.
  - tick = (pcnt == TICK_CYCLES-1).
  - On tick, idx advances 0→1→…→DIGITS-1→0.
- **Buffers**
  - Pending set P: value, dp, blank, lzs, plus a valid flag pv.
  - Active set A: drives the display.
  - On load: P ← inputs and pv ← 1.
- **Frame boundary** occurs when tick and idx == DIGITS-1:
  - If load is also high that cycle: A ← the inputs directly, pv ← 0.
  - Otherwise, if pv: A ← P, pv ← 0.
  - Otherwise A is held.
  - frame is registered high for the cycle following every boundary edge, whether or not A changed.
- **Effective blank** for digit i is one of:
  - A.blank[i], or
  - A.lzs=1, i≠0, and A.value nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never zero-suppressed.
- **Output registers**, updated every clk from the current idx and A:
  - Digit idx effectively blank: an = all ones, seg = 7'h7F, dp_n = 1.
  - Otherwise:
    - an = ~(1<<idx).
    - seg = hex decode of nibble idx.
    - dp_n = ~A.dp[idx].
- **Hex decode** (seg[6:0], 0..F):
  - 0–7: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000.
  - 8–F: 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- **Reset values**
  - pcnt=0, idx=0, pv=0, frame=0.
  - P and A: value=0, dp=0, blank=all ones, lzs=0.
  - an = all ones, seg = 7'h7F, dp_n = 1.
  - The display stays dark until the first loaded frame reaches A.
- Reset mid-frame aborts the scan immediately, and any pending load is discarded.
- Back-to-back loads within one frame: the last one wins.
- DIGITS=1: every tick is a frame boundary.

## Timing
- Cycle count: pcnt is 0 in the first clk after rst deasserts; the first tick comes TICK_CYCLES-1 edges later.
- Output latency: an, seg and dp_n follow idx/A with 1 cycle of latency. A new digit appears one clk after the tick edge.
- Load-to-display latency:
  - Minimum: 1 cycle, when load coincides with a boundary.
  - Maximum: DIGITS*TICK_CYCLES + 1 cycles.
- Frame rate: a full frame is DIGITS*TICK_CYCLES cycles; frame pulses with exactly that period.
- load has no handshake or backpressure; it is accepted every cycle.

## Test plan
Benches use DIGITS=4 and TICK_CYCLES=4.
- **Reset:** assert rst asynchronously mid-scan → same cycle shows an=4'hF, seg=7'h7F, dp_n=1. After release, first frame pulse at cycle 16 and every 16 cycles after.
- **Load and scan:** load value=16'h12AF, dp=4'b0100, blank=0, lzs=0 at cycle 2 → after the next boundary, the sequence is:
  - an=1110, seg=0001110
  - an=1101, seg=0001000
  - an=1011, seg=0100100, dp_n=0
  - an=0111, seg=1111001
  - Each step lasts 4 cycles.
- **Leading-zero suppression:**
  - value=16'h0030 with lzs=1 → digits 3 and 2 dark (an=1111 in their slots); digit 1 shows 0110000, digit 0 shows 1000000.
  - value=16'h0000 → only digit 0 lit, showing 1000000.
- **Tear-free update:** load 16'h1111, then load 16'h2222 mid-frame → the current frame keeps showing 1s; the next frame shows only 2s; the 1s pattern never mixes with 2s within a frame.
- **Simultaneous load/boundary:** load 16'h5555 on the exact boundary cycle → next frame shows 0010010 on all digits. pv is 0 afterwards, and the following frame is unchanged.
- **Blanking:** blank=4'b1010 with dp=4'b1111 → digits 1 and 3 drive an=1111 and dp_n=1 in their slots; digits 0 and 2 show dp_n=0.
